message_receiver: RTL and testbench

- Capture-side counterpart of the 9-bit message streamer. It drives the streamer's enable line and samples its 9-bit word bus once per clock.
- Each word is stored in a local buffer until a terminator word or overflow ends the capture. Length, status and an optional 9-bit running checksum are then published.
- Sits next to the streamer macro on the same clock. Typical use is as an on-chip self-check or readback path for the stored message.

---
 rtl/msg_pkg.sv | 11 +
 rtl/message_receiver_if.sv | 29 ++
 rtl/msg_rx_buffer.sv | 35 +++
 rtl/message_receiver.sv | 122 ++++++++++++
 tb/tb_message_receiver.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared word width, default terminator and FSM state type for the message receiver
package msg_pkg;
  localparam int WORD_W = 9;
  localparam logic [WORD_W-1:0] MSG_TERM_DEFAULT = 9'h000;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;
endpackage

// File: rtl/message_receiver_if.sv
// rtl/message_receiver_if.sv - streamer link, capture status and read port of the message receiver
interface message_receiver_if
  import msg_pkg::*;
#(
  parameter int DEPTH = 64
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;

  logic              start_i;
  logic [WORD_W-1:0] data_i;
  logic              run_o;
  logic              done_o;
  logic              ovf_o;
  logic [LEN_W-1:0]  len_o;
  logic [WORD_W-1:0] sum_o;
  logic [AW-1:0]     rd_addr_i;
  logic [WORD_W-1:0] rd_data_o;

  modport master (
    output start_i, data_i, rd_addr_i,
    input  run_o, done_o, ovf_o, len_o, sum_o, rd_data_o
  );

  modport slave (
    input  start_i, data_i, rd_addr_i,
    output run_o, done_o, ovf_o, len_o, sum_o, rd_data_o
  );
endinterface

// File: rtl/msg_rx_buffer.sv
// rtl/msg_rx_buffer.sv - DEPTH x WORD_W single-write single-read RAM with registered read data
module msg_rx_buffer
  import msg_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rd_data;

  // Storage is deliberately left unreset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/message_receiver.sv
// rtl/message_receiver.sv - captures streamer words until TERM or overflow; MSG_RX_SUM_EN enables the running sum
module message_receiver
  import msg_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter logic [WORD_W-1:0] TERM = MSG_TERM_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_override_n,
  message_receiver_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;
  localparam logic [LEN_W-1:0] FULL = LEN_W'(DEPTH);

  state_t           r_state, w_state_nxt;
  logic             r_run, w_run_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic             w_wr_en;
`ifdef MSG_RX_SUM_EN
  logic [WORD_W-1:0] r_sum, w_sum_nxt;
`endif

  always_ff @(posedge clk_i or negedge rst_override_n) begin
    if (!rst_override_n) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
      r_len   <= w_len_nxt;
    end
  end

`ifdef MSG_RX_SUM_EN
  always_ff @(posedge clk_i or negedge rst_override_n) begin
    if (!rst_override_n) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_sum_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_done_nxt  = r_done;
    w_ovf_nxt   = r_ovf;
    w_len_nxt   = r_len;
    w_wr_en     = 1'b0;
`ifdef MSG_RX_SUM_EN
    w_sum_nxt   = r_sum;
`endif
    case (r_state)
      IDLE, DONE: begin
        if (bus.start_i) begin
          w_state_nxt = CAPTURE;
          w_run_nxt   = 1'b1;
          w_done_nxt  = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_len_nxt   = '0;
`ifdef MSG_RX_SUM_EN
          w_sum_nxt   = '0;
`endif
        end
      end
      CAPTURE: begin
        // The streamer holds word 0 until run_o rises, so every CAPTURE edge sees a fresh word.
        if (bus.data_i == TERM) begin
          w_state_nxt = DONE;
          w_run_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (r_len == FULL) begin
          w_state_nxt = DONE;
          w_run_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_ovf_nxt   = 1'b1;
        end else begin
          w_wr_en     = 1'b1;
          w_len_nxt   = r_len + LEN_W'(1);
`ifdef MSG_RX_SUM_EN
          w_sum_nxt   = r_sum + bus.data_i;
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_run_nxt   = 1'b0;
      end
    endcase
  end

  msg_rx_buffer #(
    .DEPTH(DEPTH)
  ) u_buffer (
    .i_clk     (clk_i),
    .i_rst_n   (rst_override_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_len[AW-1:0]),
    .i_wr_data (bus.data_i),
    .i_rd_addr (bus.rd_addr_i),
    .o_rd_data (bus.rd_data_o)
  );

  assign bus.run_o  = r_run;
  assign bus.done_o = r_done;
  assign bus.ovf_o  = r_ovf;
  assign bus.len_o  = r_len;
`ifdef MSG_RX_SUM_EN
  assign bus.sum_o  = r_sum;
`else
  assign bus.sum_o  = '0;
`endif
endmodule

// File: tb/tb_message_receiver.sv
// tb/tb_message_receiver.sv - scoreboard bench for message_receiver with ROM streamer models at DEPTH 64 and 4
module tb_message_receiver;
  import msg_pkg::*;

`ifdef MSG_RX_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  typedef struct {
    int         len;
    logic [8:0] sum;
    bit         ovf;
    int         run_cyc;
    logic [8:0] words [8];
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  logic [8:0] rom_a [32];
  logic [8:0] rom_b [32];
  logic [4:0] ptr_a = '0;
  logic [4:0] ptr_b = '0;

  always #5 clk = ~clk;

  message_receiver_if #(.DEPTH(64)) bus_a ();
  message_receiver_if #(.DEPTH(4))  bus_b ();

  message_receiver #(.DEPTH(64)) dut_a (.clk_i(clk), .rst_override_n(rst_n), .bus(bus_a));
  message_receiver #(.DEPTH(4))  dut_b (.clk_i(clk), .rst_override_n(rst_n), .bus(bus_b));

  // Streamer model: pointer rewinds while run_o is low, advances while high.
  always @(posedge clk) begin
    ptr_a <= bus_a.run_o ? ptr_a + 5'd1 : 5'd0;
    ptr_b <= bus_b.run_o ? ptr_b + 5'd1 : 5'd0;
  end
  assign bus_a.data_i = rom_a[ptr_a];
  assign bus_b.data_i = rom_b[ptr_b];

  function automatic exp_t model(input bit b);
    exp_t e;
    int depth;
    logic [8:0] w;
    depth = b ? 4 : 64;
    e.len = 0; e.sum = '0; e.ovf = 1'b0; e.run_cyc = 0;
    foreach (e.words[i]) e.words[i] = '0;
    for (int i = 0; i < 32; i++) begin
      w = b ? rom_b[i] : rom_a[i];
      e.run_cyc = i + 1;
      if (w == MSG_TERM_DEFAULT) break;
      if (e.len == depth) begin e.ovf = 1'b1; break; end
      if (e.len < 8) e.words[e.len] = w;
      e.len++;
      if (SUM_EN) e.sum = e.sum + w;
    end
    return e;
  endfunction

  task automatic clear_roms();
    foreach (rom_a[i]) rom_a[i] = '0;
    foreach (rom_b[i]) rom_b[i] = '0;
  endtask

  task automatic set_start(input bit b, input logic v);
    if (b) bus_b.start_i = v; else bus_a.start_i = v;
  endtask

  task automatic do_capture(input bit b, input bit repulse, output int run_cyc,
                            output logic done, output logic ovf, output logic [9:0] len,
                            output logic [8:0] sum, output logic done0, output logic ovf0,
                            output logic [9:0] len0);
    @(negedge clk);
    set_start(b, 1'b1);
    @(negedge clk);
    set_start(b, 1'b0);
    done0 = b ? bus_b.done_o : bus_a.done_o;
    ovf0  = b ? bus_b.ovf_o  : bus_a.ovf_o;
    len0  = b ? 10'(bus_b.len_o) : 10'(bus_a.len_o);
    run_cyc = 0;
    while ((b ? bus_b.run_o : bus_a.run_o) && run_cyc < 200) begin
      run_cyc++;
      set_start(b, repulse && run_cyc == 1);
      @(negedge clk);
    end
    set_start(b, 1'b0);
    done = b ? bus_b.done_o : bus_a.done_o;
    ovf  = b ? bus_b.ovf_o  : bus_a.ovf_o;
    len  = b ? 10'(bus_b.len_o) : 10'(bus_a.len_o);
    sum  = b ? bus_b.sum_o  : bus_a.sum_o;
  endtask

  task automatic rd(input bit b, input int addr, output logic [8:0] d);
    @(negedge clk);
    if (b) bus_b.rd_addr_i = 2'(addr); else bus_a.rd_addr_i = 6'(addr);
    @(negedge clk);
    d = b ? bus_b.rd_data_o : bus_a.rd_data_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.start_i = 1'b0; bus_b.start_i = 1'b0;
    bus_a.rd_addr_i = '0; bus_b.rd_addr_i = '0;
    clear_roms();
    repeat (3) @(negedge clk);
    n_tests++; if (bus_a.run_o !== 1'b0) begin n_fail++; $display("FAIL reset_run got %b exp 0", bus_a.run_o); end
    n_tests++; if (bus_a.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus_a.done_o); end
    n_tests++; if (bus_a.ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", bus_a.ovf_o); end
    n_tests++; if (bus_a.len_o !== 7'd0) begin n_fail++; $display("FAIL reset_len got %0d exp 0", bus_a.len_o); end
    n_tests++; if (bus_a.sum_o !== 9'd0) begin n_fail++; $display("FAIL reset_sum got %h exp 0", bus_a.sum_o); end
    n_tests++; if (bus_a.rd_data_o !== 9'd0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", bus_a.rd_data_o); end
    n_tests++; if (bus_b.run_o !== 1'b0) begin n_fail++; $display("FAIL reset_run_b got %b exp 0", bus_b.run_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int rc; logic dn, ov, d0, o0; logic [9:0] ln, l0; logic [8:0] sm, rdv; exp_t e;
    clear_roms();
    rom_a[0] = 9'h048; rom_a[1] = 9'h069; rom_a[2] = 9'h000;
    exp_q.push_back(model(1'b0));
    do_capture(1'b0, 1'b0, rc, dn, ov, ln, sm, d0, o0, l0);
    n_tests++; if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_queue got 0 entries exp 1"); return; end
    e = exp_q.pop_front();
    n_tests++; if (rc !== e.run_cyc) begin n_fail++; $display("FAIL basic_run_cycles got %0d exp %0d", rc, e.run_cyc); end
    n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b exp 1", dn); end
    n_tests++; if (ov !== e.ovf) begin n_fail++; $display("FAIL basic_ovf got %b exp %b", ov, e.ovf); end
    n_tests++; if (ln !== 10'(e.len)) begin n_fail++; $display("FAIL basic_len got %0d exp %0d", ln, e.len); end
    n_tests++; if (sm !== e.sum) begin n_fail++; $display("FAIL basic_sum got %h exp %h", sm, e.sum); end
    for (int i = 0; i < e.len; i++) begin
      rd(1'b0, i, rdv);
      n_tests++; if (rdv !== e.words[i]) begin n_fail++; $display("FAIL basic_rd[%0d] got %h exp %h", i, rdv, e.words[i]); end
    end
  endtask

  task automatic test_empty();
    int rc; logic dn, ov, d0, o0; logic [9:0] ln, l0; logic [8:0] sm; exp_t e;
    clear_roms();
    exp_q.push_back(model(1'b0));
    do_capture(1'b0, 1'b0, rc, dn, ov, ln, sm, d0, o0, l0);
    e = exp_q.pop_front();
    n_tests++; if (rc !== e.run_cyc) begin n_fail++; $display("FAIL empty_run_cycles got %0d exp %0d", rc, e.run_cyc); end
    n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL empty_done got %b exp 1", dn); end
    n_tests++; if (ln !== 10'(e.len)) begin n_fail++; $display("FAIL empty_len got %0d exp %0d", ln, e.len); end
    n_tests++; if (sm !== e.sum) begin n_fail++; $display("FAIL empty_sum got %h exp %h", sm, e.sum); end
  endtask

  task automatic test_overflow();
    int rc; logic dn, ov, d0, o0; logic [9:0] ln, l0; logic [8:0] sm, rdv; exp_t e;
    clear_roms();
    for (int i = 0; i < 31; i++) rom_b[i] = 9'(i + 1);
    exp_q.push_back(model(1'b1));
    do_capture(1'b1, 1'b0, rc, dn, ov, ln, sm, d0, o0, l0);
    e = exp_q.pop_front();
    n_tests++; if (rc !== e.run_cyc) begin n_fail++; $display("FAIL ovf_run_cycles got %0d exp %0d", rc, e.run_cyc); end
    n_tests++; if (ov !== e.ovf) begin n_fail++; $display("FAIL ovf_flag got %b exp %b", ov, e.ovf); end
    n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL ovf_done got %b exp 1", dn); end
    n_tests++; if (ln !== 10'(e.len)) begin n_fail++; $display("FAIL ovf_len got %0d exp %0d", ln, e.len); end
    n_tests++; if (sm !== e.sum) begin n_fail++; $display("FAIL ovf_sum got %h exp %h", sm, e.sum); end
    for (int i = 0; i < e.len; i++) begin
      rd(1'b1, i, rdv);
      n_tests++; if (rdv !== e.words[i]) begin n_fail++; $display("FAIL ovf_rd[%0d] got %h exp %h", i, rdv, e.words[i]); end
    end
  endtask

  task automatic test_sum_wrap();
    int rc; logic dn, ov, d0, o0; logic [9:0] ln, l0; logic [8:0] sm; exp_t e;
    clear_roms();
    rom_a[0] = 9'h1FF; rom_a[1] = 9'h002;
    exp_q.push_back(model(1'b0));
    do_capture(1'b0, 1'b0, rc, dn, ov, ln, sm, d0, o0, l0);
    e = exp_q.pop_front();
    n_tests++; if (sm !== e.sum) begin n_fail++; $display("FAIL sum_wrap got %h exp %h", sm, e.sum); end
    n_tests++; if (ln !== 10'(e.len)) begin n_fail++; $display("FAIL sum_wrap_len got %0d exp %0d", ln, e.len); end
  endtask

  task automatic test_restart();
    int rc; logic dn, ov, d0, o0; logic [9:0] ln, l0; logic [8:0] sm; exp_t e;
    clear_roms();
    for (int i = 0; i < 31; i++) rom_b[i] = 9'(i + 1);
    exp_q.push_back(model(1'b1));
    do_capture(1'b1, 1'b0, rc, dn, ov, ln, sm, d0, o0, l0);
    e = exp_q.pop_front();
    n_tests++; if (ov !== 1'b1) begin n_fail++; $display("FAIL restart_pre_ovf got %b exp 1", ov); end
    clear_roms();
    rom_b[0] = 9'h005; rom_b[1] = 9'h006; rom_b[2] = 9'h007;
    exp_q.push_back(model(1'b1));
    do_capture(1'b1, 1'b1, rc, dn, ov, ln, sm, d0, o0, l0);
    e = exp_q.pop_front();
    n_tests++; if (d0 !== 1'b0) begin n_fail++; $display("FAIL restart_done_clear got %b exp 0", d0); end
    n_tests++; if (o0 !== 1'b0) begin n_fail++; $display("FAIL restart_ovf_clear got %b exp 0", o0); end
    n_tests++; if (l0 !== 10'd0) begin n_fail++; $display("FAIL restart_len_clear got %0d exp 0", l0); end
    n_tests++; if (rc !== e.run_cyc) begin n_fail++; $display("FAIL restart_run_cycles got %0d exp %0d", rc, e.run_cyc); end
    n_tests++; if (ln !== 10'(e.len)) begin n_fail++; $display("FAIL restart_len got %0d exp %0d", ln, e.len); end
    n_tests++; if (ov !== e.ovf) begin n_fail++; $display("FAIL restart_ovf got %b exp %b", ov, e.ovf); end
    n_tests++; if (sm !== e.sum) begin n_fail++; $display("FAIL restart_sum got %h exp %h", sm, e.sum); end
  endtask

  task automatic test_reset_mid();
    int rc; logic dn, ov, d0, o0; logic [9:0] ln, l0; logic [8:0] sm, rdv; exp_t e;
    clear_roms();
    rom_a[0] = 9'h011; rom_a[1] = 9'h022; rom_a[2] = 9'h033; rom_a[3] = 9'h044;
    @(negedge clk); bus_a.start_i = 1'b1;
    @(negedge clk); bus_a.start_i = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus_a.run_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_run got %b exp 1", bus_a.run_o); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus_a.run_o !== 1'b0) begin n_fail++; $display("FAIL midrst_run got %b exp 0", bus_a.run_o); end
    n_tests++; if (bus_a.done_o !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", bus_a.done_o); end
    n_tests++; if (bus_a.len_o !== 7'd0) begin n_fail++; $display("FAIL midrst_len got %0d exp 0", bus_a.len_o); end
    @(negedge clk); rst_n = 1'b1;
    rom_a[0] = 9'h055;
    exp_q.push_back(model(1'b0));
    do_capture(1'b0, 1'b0, rc, dn, ov, ln, sm, d0, o0, l0);
    e = exp_q.pop_front();
    n_tests++; if (ln !== 10'(e.len)) begin n_fail++; $display("FAIL midrst_len_after got %0d exp %0d", ln, e.len); end
    n_tests++; if (rc !== e.run_cyc) begin n_fail++; $display("FAIL midrst_run_cycles got %0d exp %0d", rc, e.run_cyc); end
    rd(1'b0, 0, rdv);
    n_tests++; if (rdv !== e.words[0]) begin n_fail++; $display("FAIL midrst_buf0 got %h exp %h", rdv, e.words[0]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_sum_wrap();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
